// File: rtl/seq_muldiv.sv
// Sequential unsigned multiplier / restoring divider, one bit per cycle.
// Fixed latency of WIDTH+2 cycles from accepted start to the done pulse.
module seq_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             ctrl_stop,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               mode_r;
    logic [WIDTH-1:0]   op_a_r;
    logic [WIDTH-1:0]   op_b_r;
    logic [WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]   sh_r;
    logic [WIDTH-1:0]   acc_step_s;
    logic [WIDTH-1:0]   sh_step_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH-1:0]   diff_s;
    logic               div_zero_s;
    logic               ready_r;
    logic               done_r;
    logic [WIDTH-1:0]   result_hi_r;
    logic [WIDTH-1:0]   result_lo_r;
    logic               div_by_zero_r;

    assign div_zero_s  = mode_r && (op_b_r == {WIDTH{1'b0}});
    assign ready       = ready_r;
    assign done        = done_r;
    assign result_hi   = result_hi_r;
    assign result_lo   = result_lo_r;
    assign div_by_zero = div_by_zero_r;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; abort wins over completion in LOAD and RUN
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = LOAD;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            LOAD: begin
                if (ctrl_stop) begin
                    state_nx_s = IDLE;
                end else if (div_zero_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            RUN: begin
                if (ctrl_stop) begin
                    state_nx_s = IDLE;
                end else if (cnt_r == CNT_W'(1)) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // One iteration: multiply adds and shifts {acc,sh} right; divide shifts left and restores
    always_comb begin
        sum_s      = {1'b0, acc_r} + (sh_r[0] ? {1'b0, op_a_r} : {(WIDTH + 1){1'b0}});
        rem_sh_s   = {acc_r, sh_r[WIDTH-1]};
        diff_s     = rem_sh_s[WIDTH-1:0] - op_b_r;
        acc_step_s = acc_r;
        sh_step_s  = sh_r;
        if (!mode_r) begin
            acc_step_s = sum_s[WIDTH:1];
            sh_step_s  = {sum_s[0], sh_r[WIDTH-1:1]};
        end else if (rem_sh_s >= {1'b0, op_b_r}) begin
            acc_step_s = diff_s;
            sh_step_s  = {sh_r[WIDTH-2:0], 1'b1};
        end else begin
            acc_step_s = rem_sh_s[WIDTH-1:0];
            sh_step_s  = {sh_r[WIDTH-2:0], 1'b0};
        end
    end

    // Operand capture, iteration datapath and counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_r <= 1'b0;
            op_a_r <= {WIDTH{1'b0}};
            op_b_r <= {WIDTH{1'b0}};
            acc_r  <= {WIDTH{1'b0}};
            sh_r   <= {WIDTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mode_r <= mode;
                        op_a_r <= op_a;
                        op_b_r <= op_b;
                    end
                end
                LOAD: begin
                    acc_r <= {WIDTH{1'b0}};
                    sh_r  <= mode_r ? op_a_r : op_b_r;
                    cnt_r <= CNT_W'(WIDTH);
                end
                RUN: begin
                    acc_r <= acc_step_s;
                    sh_r  <= sh_step_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                end
                DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Registered status and results; results only move on entry to DONE
    always_ff @(posedge clk) begin
        if (!reset) begin
            ready_r       <= 1'b1;
            done_r        <= 1'b0;
            result_hi_r   <= {WIDTH{1'b0}};
            result_lo_r   <= {WIDTH{1'b0}};
            div_by_zero_r <= 1'b0;
        end else begin
            ready_r <= (state_nx_s == IDLE);
            done_r  <= (state_nx_s == DONE);
            if (state_nx_s == DONE && state_r == LOAD) begin
                result_hi_r   <= op_a_r;
                result_lo_r   <= {WIDTH{1'b1}};
                div_by_zero_r <= 1'b1;
            end else if (state_nx_s == DONE) begin
                result_hi_r   <= acc_step_s;
                result_lo_r   <= sh_step_s;
                div_by_zero_r <= 1'b0;
            end else begin
                result_hi_r   <= result_hi_r;
                result_lo_r   <= result_lo_r;
                div_by_zero_r <= div_by_zero_r;
            end
        end
    end

endmodule

// File: tb/tb_seq_muldiv.sv
// Self-checking bench for seq_muldiv at WIDTH=8: directed table, corner
// sequences (abort, reset mid-operation) and randomized ops vs. an arithmetic model.
module tb_seq_muldiv;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       mode;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       ctrl_stop;
    logic       ready;
    logic       done;
    logic [7:0] result_hi;
    logic [7:0] result_lo;
    logic       div_by_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_muldiv #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .op_a        (op_a),
        .op_b        (op_b),
        .ctrl_stop   (ctrl_stop),
        .ready       (ready),
        .done        (done),
        .result_hi   (result_hi),
        .result_lo   (result_lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       m;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] hi;
        logic [7:0] lo;
        logic       dz;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic on the operands
    task automatic model(input logic m, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] hi, output logic [7:0] lo,
                         output logic dz, output int lat);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        if (!m) begin
            hi = p[15:8]; lo = p[7:0]; dz = 1'b0; lat = 10;
        end else if (b == 8'd0) begin
            hi = a; lo = 8'hFF; dz = 1'b1; lat = 2;
        end else begin
            hi = a % b; lo = a / b; dz = 1'b0; lat = 10;
        end
    endtask

    // Launch an op (cycle 0 = start cycle) and wait for done; also checks hold of outputs
    task automatic do_op(input bit sync, input logic m, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output logic [7:0] hi, output logic [7:0] lo,
                         output logic dz);
        int         cyc;
        int         hold_bad;
        logic [7:0] ph;
        logic [7:0] pl;
        if (sync) begin
            @(posedge clk); #1;
        end
        start = 1'b1; mode = m; op_a = a; op_b = b;
        ph = result_hi; pl = result_lo;
        hold_bad = 0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        lat = -1; hi = 8'hxx; lo = 8'hxx; dz = 1'bx;
        while (cyc < 40) begin
            @(negedge clk);
            if (done) begin
                lat = cyc; hi = result_hi; lo = result_lo; dz = div_by_zero;
                break;
            end
            if (result_hi !== ph || result_lo !== pl) hold_bad++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("hold_during_op", hold_bad, 0);
    endtask

    vec_t vt[6];

    initial begin
        int         lat;
        logic [7:0] hi;
        logic [7:0] lo;
        logic       dz;
        logic [7:0] ehi;
        logic [7:0] elo;
        logic       edz;
        int         elat;
        int         seen_done;
        int         not_ready;

        vt[0] = '{1'b0, 8'd13,  8'd11,  8'h00, 8'h8F, 1'b0, 10};
        vt[1] = '{1'b0, 8'd255, 8'd255, 8'hFE, 8'h01, 1'b0, 10};
        vt[2] = '{1'b1, 8'd200, 8'd7,   8'd4,  8'd28, 1'b0, 10};
        vt[3] = '{1'b1, 8'd5,   8'd9,   8'd5,  8'd0,  1'b0, 10};
        vt[4] = '{1'b1, 8'd100, 8'd0,   8'd100, 8'hFF, 1'b1, 2};
        vt[5] = '{1'b0, 8'd2,   8'd3,   8'h00, 8'd6,  1'b0, 10};

        reset = 1'b0; start = 1'b0; mode = 1'b0; op_a = 8'd0; op_b = 8'd0; ctrl_stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_hi", result_hi, 0);
        chk("rst_lo", result_lo, 0);
        chk("rst_dbz", div_by_zero, 0);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_op(1'b1, vt[i].m, vt[i].a, vt[i].b, lat, hi, lo, dz);
            chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("vec%0d_hi", i), hi, vt[i].hi);
            chk($sformatf("vec%0d_lo", i), lo, vt[i].lo);
            chk($sformatf("vec%0d_dbz", i), dz, vt[i].dz);
        end

        // Abort mid-run; a start pulse during RUN must be ignored
        do_op(1'b1, 1'b0, 8'd13, 8'd11, lat, hi, lo, dz);
        chk("pre_stop_lo", lo, 8'h8F);
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; op_a = 8'd9; op_b = 8'd9;
        seen_done = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            start = (c == 3);
            ctrl_stop = (c == 5);
            if (done) seen_done++;
            if (c == 3) chk("ready_in_run", ready, 0);
        end
        ctrl_stop = 1'b0;
        chk("stop_ready_c6", ready, 1);
        chk("stop_hi", result_hi, 8'h00);
        chk("stop_lo", result_lo, 8'h8F);
        not_ready = 0;
        for (int c = 7; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done) seen_done++;
            if (!ready) not_ready++;
        end
        chk("stop_no_done", seen_done, 0);
        chk("stop_stays_idle", not_ready, 0);

        // Reset in cycle 4 of a divide, then start on the first edge out of reset
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b1; op_a = 8'd200; op_b = 8'd7;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            reset = (c == 4) ? 1'b0 : 1'b1;
        end
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_hi", result_hi, 0);
        chk("mid_rst_lo", result_lo, 0);
        chk("mid_rst_dbz", div_by_zero, 0);
        do_op(1'b0, 1'b0, 8'd6, 8'd7, lat, hi, lo, dz);
        chk("post_rst_lat", lat, 10);
        chk("post_rst_lo", lo, 8'd42);
        chk("post_rst_hi", hi, 8'd0);

        // Randomized operations
        for (int i = 0; i < 200; i++) begin
            logic       m;
            logic [7:0] a;
            logic [7:0] b;
            m = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            model(m, a, b, ehi, elo, edz, elat);
            do_op(1'b1, m, a, b, lat, hi, lo, dz);
            chk($sformatf("rnd%0d_lat", i), lat, elat);
            chk($sformatf("rnd%0d_hi", i), hi, ehi);
            chk($sformatf("rnd%0d_lo", i), lo, elo);
            chk($sformatf("rnd%0d_dbz", i), dz, edz);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_muldiv.md
SEQ_MULDIV -- requirements
Module: seq_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand width in bits, legal values 4..32.
REQ-002 The block SHALL have input clk (1 bit): single clock, all state updates on its rising edge.
REQ-003 The block SHALL have input reset (1 bit): synchronous, active-low reset.
REQ-004 The block SHALL have input start (1 bit): operation request, sampled only while ready=1.
REQ-005 The block SHALL have input mode (1 bit): 0 = unsigned multiply, 1 = unsigned divide, sampled with start.
REQ-006 The block SHALL have input op_a (WIDTH bits): multiplicand or dividend, sampled with start.
REQ-007 The block SHALL have input op_b (WIDTH bits): multiplier or divisor, sampled with start.
REQ-008 The block SHALL have input ctrl_stop (1 bit): abort of the operation in flight.
REQ-009 The block SHALL have output ready (1 bit): block idle and accepting start.
REQ-010 The block SHALL have output done (1 bit): single-cycle completion pulse.
REQ-011 The block SHALL have output result_hi (WIDTH bits): product upper half in multiply mode, remainder in divide mode.
REQ-012 The block SHALL have output result_lo (WIDTH bits): product lower half in multiply mode, quotient in divide mode.
REQ-013 The block SHALL have output div_by_zero (1 bit): last completed divide had op_b=0.

Function
REQ-014 The FSM SHALL use states IDLE, LOAD, RUN, DONE; ready SHALL be 1 only in IDLE.
REQ-015 In IDLE, start=1 SHALL capture mode/op_a/op_b and move to LOAD; start outside IDLE SHALL be ignored.
REQ-016 In LOAD, internal accumulator and shift registers SHALL be initialised, the iteration counter SHALL be set to WIDTH, and the FSM SHALL move to RUN.
REQ-017 In RUN, one shift-add (multiply) or restoring shift-subtract (divide) step SHALL occur per cycle; the counter SHALL decrement and the FSM SHALL move to DONE after exactly WIDTH RUN cycles.
REQ-018 In DONE, done=1 and result_hi/result_lo/div_by_zero SHALL be updated in that cycle; the next state SHALL be IDLE unconditionally.
REQ-019 Latency SHALL be fixed: start sampled in cycle 0 gives done=1 in cycle WIDTH+2.
REQ-020 Multiply SHALL give {result_hi,result_lo} = op_a*op_b, full 2*WIDTH-bit unsigned product, no overflow.
REQ-021 Divide SHALL give result_lo = floor(op_a/op_b) and result_hi = op_a mod op_b, unsigned.
REQ-022 For divide with op_b=0, LOAD SHALL go directly to DONE (done in cycle 2), with result_lo = all ones, result_hi = op_a, and div_by_zero=1.
REQ-023 div_by_zero SHALL be 0 after any completed multiply and after any divide with nonzero op_b.
REQ-024 Output registers SHALL hold their values from DONE until the next DONE; intermediate RUN values SHALL never be visible on the outputs.
REQ-025 ctrl_stop=1 in LOAD or RUN SHALL return the FSM to IDLE on the next edge, with no done pulse and outputs unchanged.
REQ-026 ctrl_stop SHALL have no effect in IDLE or DONE; ctrl_stop=1 and start=1 together in IDLE SHALL start the operation.
REQ-027 start=1 in the DONE cycle SHALL be ignored; a new operation can be accepted in the following IDLE cycle, giving a throughput of one operation per WIDTH+3 cycles.

Reset
REQ-028 reset=0 at a rising edge SHALL force IDLE, ready=1, done=0, result_hi=0, result_lo=0, div_by_zero=0, counter=0, in any state, including mid-operation.
REQ-029 reset SHALL take priority over start and ctrl_stop; the first start can be accepted on the first edge with reset=1.

Verification (WIDTH=8)
REQ-030 The bench SHALL drive a multiply of 13*11, start in cycle 0 -> done=1 in cycle 10, result_hi=0x00, result_lo=0x8F, div_by_zero=0.
REQ-031 The bench SHALL drive a multiply of 255*255 -> result_hi=0xFE, result_lo=0x01.
REQ-032 The bench SHALL drive a divide of 200/7 -> done in cycle 10, result_lo=28, result_hi=4; then 5/9 -> result_lo=0, result_hi=5.
REQ-033 The bench SHALL drive a divide of 100/0 -> done in cycle 2, result_lo=0xFF, result_hi=100, div_by_zero=1; then a multiply of 2*3 -> div_by_zero=0, result_lo=6.
REQ-034 The bench SHALL complete 13*11, then start 9*9 and pulse ctrl_stop in cycle 5 -> IDLE and ready=1 in cycle 6, no done pulse, outputs still 0x00/0x8F; a start pulse during RUN SHALL be ignored.
REQ-035 The bench SHALL drive reset=0 in cycle 4 of a divide -> cycle 5 shows ready=1 and all outputs 0; an immediate 6*7 SHALL then complete with result_lo=42.
